// File: rtl/plle2_lock_sequencer.sv
// Power-up / reset / lock-acquisition sequencer for a single PLLE2 instance.
// Drives PWRDWN, RST and CLKINSEL, qualifies LOCKED, retries and latches a fault.
module plle2_lock_sequencer #(
    parameter int unsigned PWRDWN_CYCLES = 16,
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 64,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clkinsel,
    input  logic       pll_locked,
    output logic       pll_pwrdwn,
    output logic       pll_rst,
    output logic       pll_clkinsel,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retries,
    output logic [2:0] state
);

    localparam int unsigned MAX_AB  = (PWRDWN_CYCLES > RST_CYCLES) ? PWRDWN_CYCLES : RST_CYCLES;
    localparam int unsigned MAX_CD  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PWRDN = 3'd1,
        ST_PRST  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STAB  = 3'd4,
        ST_LOCKD = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [3:0]    retries_nxt;
    logic          lost_nxt;
    logic          fail;
    logic          sync1;
    logic          lk;

    assign state = 3'(cur);

    // Two-flop synchroniser for the asynchronous LOCKED input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk    <= sync1;
        end
    end

    // Next-state, retry bookkeeping and phase timer
    always_comb begin
        nxt         = cur;
        retries_nxt = retries;
        lost_nxt    = 1'b0;
        fail        = 1'b0;
        timer_nxt   = timer;

        if (!enable) begin
            nxt         = ST_IDLE;
            retries_nxt = 4'd0;
        end else if ((cur == ST_WAIT || cur == ST_STAB || cur == ST_LOCKD)
                     && (clkinsel != pll_clkinsel)) begin
            nxt = ST_PWRDN;
        end else begin
            case (cur)
                ST_IDLE:  nxt = ST_PWRDN;
                ST_PWRDN: if (timer == TW'(PWRDWN_CYCLES - 1)) nxt = ST_PRST;
                ST_PRST:  if (timer == TW'(RST_CYCLES - 1)) nxt = ST_WAIT;
                ST_WAIT: begin
                    if (lk) nxt = ST_STAB;
                    else if (timer == TW'(LOCK_TIMEOUT - 1)) fail = 1'b1;
                end
                ST_STAB: begin
                    if (!lk) begin
                        fail = 1'b1;
                    end else if (timer == TW'(STABLE_CYCLES - 1)) begin
                        nxt         = ST_LOCKD;
                        retries_nxt = 4'd0;
                    end
                end
                ST_LOCKD: begin
                    if (!lk) begin
                        nxt      = ST_PRST;
                        lost_nxt = 1'b1;
                    end
                end
                ST_FAULT: nxt = ST_FAULT;
                default:  nxt = ST_IDLE;
            endcase

            if (fail) begin
                if (retries == 4'(MAX_RETRIES - 1)) begin
                    nxt         = ST_FAULT;
                    retries_nxt = 4'(MAX_RETRIES);
                end else begin
                    nxt         = ST_PRST;
                    retries_nxt = retries + 4'd1;
                end
            end
        end

        // Timer restarts on every state entry and only runs in timed phases
        if (nxt != cur) begin
            timer_nxt = '0;
        end else if (cur == ST_PWRDN || cur == ST_PRST || cur == ST_WAIT || cur == ST_STAB) begin
            timer_nxt = timer + TW'(1);
        end
    end

    // State register and registered outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur          <= ST_IDLE;
            timer        <= '0;
            retries      <= 4'd0;
            lock_lost    <= 1'b0;
            ready        <= 1'b0;
            fault        <= 1'b0;
            pll_pwrdwn   <= 1'b1;
            pll_rst      <= 1'b1;
            pll_clkinsel <= 1'b0;
        end else begin
            cur        <= nxt;
            timer      <= timer_nxt;
            retries    <= retries_nxt;
            lock_lost  <= lost_nxt;
            ready      <= (nxt == ST_LOCKD);
            fault      <= (nxt == ST_FAULT);
            pll_pwrdwn <= (nxt == ST_IDLE) || (nxt == ST_PWRDN) || (nxt == ST_FAULT);
            pll_rst    <= !((nxt == ST_WAIT) || (nxt == ST_STAB) || (nxt == ST_LOCKD));
            if (nxt == ST_PWRDN && cur != ST_PWRDN) begin
                pll_clkinsel <= clkinsel;
            end
        end
    end

endmodule

// File: tb/tb_plle2_lock_sequencer.sv
// Self-checking bench: directed lock scenarios with literal expectations plus
// randomized stimulus compared every cycle against a phase/count behavioural model.
module tb_plle2_lock_sequencer;

    localparam int P_PD = 4;
    localparam int P_RS = 2;
    localparam int P_TO = 32;
    localparam int P_ST = 8;
    localparam int P_MR = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_PWRDN = 1;
    localparam int PH_PRST  = 2;
    localparam int PH_WAIT  = 3;
    localparam int PH_STAB  = 4;
    localparam int PH_LOCKD = 5;
    localparam int PH_FAULT = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clkinsel = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_pwrdwn;
    logic       pll_rst;
    logic       pll_clkinsel;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [3:0] retries;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: current phase, cycles spent in it, and sticky facts
    int m_phase, m_cnt, m_ret;
    bit m_sel, m_lost, m_s1, m_s2;

    plle2_lock_sequencer #(
        .PWRDWN_CYCLES(P_PD), .RST_CYCLES(P_RS), .LOCK_TIMEOUT(P_TO),
        .STABLE_CYCLES(P_ST), .MAX_RETRIES(P_MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clkinsel(clkinsel),
        .pll_locked(pll_locked), .pll_pwrdwn(pll_pwrdwn), .pll_rst(pll_rst),
        .pll_clkinsel(pll_clkinsel), .ready(ready), .fault(fault),
        .lock_lost(lock_lost), .retries(retries), .state(state)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_phase = PH_IDLE; m_cnt = 0; m_ret = 0;
        m_sel = 1'b0; m_lost = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic m_step();
        bit locked_now;
        bit failed;
        int np;
        locked_now = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        m_lost = 1'b0;
        failed = 1'b0;
        np = m_phase;
        if (!enable) begin
            np = PH_IDLE;
            m_ret = 0;
        end else if (m_phase inside {PH_WAIT, PH_STAB, PH_LOCKD} && clkinsel != m_sel) begin
            np = PH_PWRDN;
        end else if (m_phase == PH_IDLE) begin
            np = PH_PWRDN;
        end else if (m_phase == PH_PWRDN && m_cnt + 1 == P_PD) begin
            np = PH_PRST;
        end else if (m_phase == PH_PRST && m_cnt + 1 == P_RS) begin
            np = PH_WAIT;
        end else if (m_phase == PH_WAIT) begin
            if (locked_now) np = PH_STAB;
            else if (m_cnt + 1 == P_TO) failed = 1'b1;
        end else if (m_phase == PH_STAB) begin
            if (!locked_now) failed = 1'b1;
            else if (m_cnt + 1 == P_ST) begin np = PH_LOCKD; m_ret = 0; end
        end else if (m_phase == PH_LOCKD && !locked_now) begin
            np = PH_PRST;
            m_lost = 1'b1;
        end
        if (failed) begin
            m_ret = m_ret + 1;
            np = (m_ret == P_MR) ? PH_FAULT : PH_PRST;
        end
        if (np == PH_PWRDN && m_phase != PH_PWRDN) m_sel = clkinsel;
        m_cnt = (np == m_phase) ? m_cnt + 1 : 0;
        m_phase = np;
    endtask

    function automatic logic [12:0] model_vec();
        logic pd, rs;
        pd = (m_phase inside {PH_IDLE, PH_PWRDN, PH_FAULT});
        rs = (m_phase inside {PH_IDLE, PH_PWRDN, PH_PRST, PH_FAULT});
        return {pd, rs, m_sel, m_phase == PH_LOCKD, m_phase == PH_FAULT, m_lost,
                4'(m_ret), 3'(m_phase)};
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Advance n clock cycles; outputs are compared to the model at each falling edge
    task automatic tick(input int n);
        logic [12:0] got;
        logic [12:0] exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_en) begin
                got = {pll_pwrdwn, pll_rst, pll_clkinsel, ready, fault, lock_lost, retries, state};
                exp = model_vec();
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL model_cycle: got %b expected %b at %0t", got, exp, $time);
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pwrdwn"}, int'(pll_pwrdwn), 1);
        check({tag, "_rst"}, int'(pll_rst), 1);
        check({tag, "_clkinsel"}, int'(pll_clkinsel), 0);
        check({tag, "_ready"}, int'(ready), 0);
        check({tag, "_fault"}, int'(fault), 0);
        check({tag, "_lost"}, int'(lock_lost), 0);
        check({tag, "_retries"}, int'(retries), 0);
        check({tag, "_state"}, int'(state), 0);
    endtask

    initial begin
        int seg;
        enable = 1'b1;
        tick(3);
        chk_en = 1'b1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Power-up sequence and first lock
        tick(1);
        check("pwrdn_state", int'(state), 1);
        check("pwrdn_pd", int'(pll_pwrdwn), 1);
        tick(4);
        check("prst_state", int'(state), 2);
        check("prst_pd", int'(pll_pwrdwn), 0);
        check("prst_rst", int'(pll_rst), 1);
        tick(2);
        check("wait_state", int'(state), 3);
        check("wait_rst", int'(pll_rst), 0);
        pll_locked = 1'b1;
        tick(10);
        check("stab_state", int'(state), 4);
        check("stab_ready", int'(ready), 0);
        tick(1);
        check("lock_ready", int'(ready), 1);
        check("lock_retries", int'(retries), 0);

        // Lock loss while ready
        pll_locked = 1'b0;
        tick(3);
        check("lost_pulse", int'(lock_lost), 1);
        check("lost_ready", int'(ready), 0);
        check("lost_state", int'(state), 2);
        tick(1);
        check("lost_pulse_end", int'(lock_lost), 0);

        // Glitch during STAB then clean relock
        pll_locked = 1'b1;
        tick(3);
        check("glitch_pre_state", int'(state), 4);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        check("glitch_state", int'(state), 2);
        check("glitch_retries", int'(retries), 1);
        tick(11);
        check("relock_ready", int'(ready), 1);
        check("relock_retries", int'(retries), 0);

        // Input-select change while locked restarts from PWRDN
        clkinsel = 1'b1;
        tick(1);
        check("sel_state", int'(state), 1);
        check("sel_applied", int'(pll_clkinsel), 1);
        check("sel_ready", int'(ready), 0);
        check("sel_nolost", int'(lock_lost), 0);
        tick(15);
        check("sel_relock", int'(ready), 1);
        clkinsel = 1'b0;
        pll_locked = 1'b0;
        tick(1);
        check("sel2_state", int'(state), 1);
        tick(6);
        check("sel2_wait", int'(state), 3);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        tick(1);
        rst_n = 1'b1;

        // Repeated timeouts into FAULT
        tick(1);
        tick(37);
        check("to1_pre", int'(state), 3);
        tick(1);
        check("to1_state", int'(state), 2);
        check("to1_retries", int'(retries), 1);
        tick(34);
        check("to2_retries", int'(retries), 2);
        tick(33);
        check("to3_pre", int'(state), 3);
        tick(1);
        check("fault_state", int'(state), 6);
        check("fault_flag", int'(fault), 1);
        check("fault_retries", int'(retries), 3);
        check("fault_pd", int'(pll_pwrdwn), 1);
        check("fault_rst", int'(pll_rst), 1);
        tick(5);
        check("fault_hold", int'(state), 6);

        // Leave FAULT by dropping enable for one cycle
        enable = 1'b0;
        tick(1);
        check("clr_state", int'(state), 0);
        check("clr_fault", int'(fault), 0);
        check("clr_retries", int'(retries), 0);
        enable = 1'b1;
        tick(1);
        check("restart_state", int'(state), 1);

        // Randomized traffic, checked against the model every cycle
        seg = 0;
        for (int c = 0; c < 6000; c++) begin
            if (seg == 0) begin
                pll_locked = ~pll_locked;
                if (pll_locked) seg = int'($urandom_range(60, 1));
                else if ($urandom_range(3, 0) == 0) seg = int'($urandom_range(3, 1));
                else seg = int'($urandom_range(140, 20));
            end
            seg--;
            if (!enable) enable = ($urandom_range(3, 0) == 0);
            else if ($urandom_range(249, 0) == 0) enable = 1'b0;
            if ($urandom_range(199, 0) == 0) clkinsel = ~clkinsel;
            if ($urandom_range(1499, 0) == 0) begin
                #2 rst_n = 1'b0;
                tick(int'($urandom_range(3, 1)));
                rst_n = 1'b1;
            end
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
